select_sequencer_3bit: RTL and testbench
========================================

Name: select_sequencer_3bit

Overview:
- Upstream control stage for the 3-to-8 decoder. It produces the EN, W2, W1 and W0 inputs that select one of eight decoder outputs.
- It scans positions 0..7, either free-running with a programmable dwell time or single-stepped. Direction is selectable, and masked-off positions are skipped.
- All outputs are registered, so the decoder sees glitch-free selects.

Parameters:
- DWELL, default 4: clock cycles each position is held in RUN. Legal range is 1..2^CNT_W-1.
- CNT_W, default 16: width of the dwell counter.

Ports:
- Clock, input, 1: system clock. All logic is rising-edge.
- Reset, input, 1: asynchronous, active-high reset.
- Start, input, 1: level input. Rising edge starts or resumes scanning.
- Stop, input, 1: level input. Rising edge pauses, or from PAUSE returns to IDLE.
- Step, input, 1: level input. Rising edge advances one position, in PAUSE only.
- Dir, input, 1: 0 = ascending (0→7), 1 = descending (7→0).
- Mask, input, 8: Mask[i]=1 means position i is eligible.
- EN, output, 1: decoder enable.
- W2, W1, W0, output, 1 each: current position, MSB first.
- Busy, output, 1: high in RUN or PAUSE.
- Wrap, output, 1: one-cycle pulse when an advance crosses the 7→0 boundary (ascending) or the 0→7 boundary (descending).

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - State = IDLE, position = 0, dwell counter = 0, edge-detect registers = 0.
  - EN=0, {W2,W1,W0}=000, Busy=0, Wrap=0.
- Edge detection:
  - Start, Stop and Step each have an internal prior-value register. An event is current=1 and prior=0.
  - A held input acts once.
- Event priority when events occur in the same cycle: Stop > Start > Step.
- States:
  - IDLE:
    - Start event → RUN.
    - Position is loaded with the first eligible position: search upward from 0 if Dir=0, downward from 7 if Dir=1.
    - If Mask=0, load 0.
    - Stop and Step are ignored.
  - RUN:
    - The dwell counter increments every cycle.
    - When the counter reaches DWELL-1, it clears and the position advances.
    - Stop event → PAUSE. The position holds and the counter clears.
    - Start and Step are ignored.
  - PAUSE:
    - Position holds.
    - Step event → advance once.
    - Start event → RUN, with the counter cleared.
    - Stop event → IDLE, with the position cleared to 0.
- Advance rule:
  - Next position = nearest index in direction Dir, modulo 8, whose Mask bit is 1.
  - If the current position is the only eligible one, the position is unchanged and Wrap pulses.
  - If Mask=0, the position is unchanged and Wrap=0.
  - Wrap=1 in the cycle the new position appears, if the search passed the boundary.
- Dir and Mask are sampled at each advance. A change takes effect at the next advance; there is no immediate jump.
- Outputs:
  - EN = (state≠IDLE) AND Mask[position], registered. This means a position masked while displayed blanks on the next cycle.
  - Busy = state≠IDLE.
- Latency:
  - A Start edge sampled at edge n gives EN, W and Busy valid after edge n+1 (one-cycle register latency).
  - In RUN, the first advance occurs DWELL cycles after RUN is entered.
- DWELL=1: the position advances every cycle in RUN.

Test Plan:
- Reset mid-RUN, asserted between clock edges → EN=0, W=000, Busy=0 immediately; these hold while Reset=1.
- Mask=FF, Dir=0, DWELL=4, Start pulse → W sequence 0,1,…,7,0 with each value held 4 cycles; Wrap=1 for exactly one cycle when W returns to 0.
- Mask=8'b1010_0100, Dir=1, Start → first position 7; the sequence is 7,5,2,7,…; Wrap pulses on the 2→7 transition.
- RUN, Stop pulse → PAUSE with W held. Holding Step high for 10 cycles advances exactly one position. A second Stop → IDLE, EN=0, W=000.
- Start and Stop both rise in the same cycle from PAUSE → Stop wins: state IDLE, Busy=0.
- Mask=8'b0000_1000, RUN → W stays 3, EN=1, Wrap pulses every DWELL cycles. Clearing Mask to 00 → EN=0 next cycle, Wrap stays 0.

Source files
------------

// File: rtl/select_sequencer_3bit_if.sv
// Control/status bundle between the select sequencer and its host.
interface select_sequencer_3bit_if;
  logic       start;
  logic       stop;
  logic       step;
  logic       dir;
  logic [7:0] mask;
  logic       en;
  logic       w2;
  logic       w1;
  logic       w0;
  logic       busy;
  logic       wrap;

  modport master (
    output start, stop, step, dir, mask,
    input  en, w2, w1, w0, busy, wrap
  );

  modport slave (
    input  start, stop, step, dir, mask,
    output en, w2, w1, w0, busy, wrap
  );
endinterface

// File: rtl/select_sequencer_3bit.sv
// Select sequencer for a 3-to-8 decoder: scans eligible positions,
// free-running with a dwell time or single-stepped, with registered selects.
module select_sequencer_3bit #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  select_sequencer_3bit_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]       state;
  logic [2:0]       pos;
  logic [CNT_W-1:0] cnt;
  logic             start_q, stop_q, step_q;
  logic             wrap_q;

  logic             start_ev, stop_ev, step_ev;
  logic             dwell_done;

  logic [2:0]       adv_pos;
  logic             adv_wrap;
  logic             adv_found;
  logic [2:0]       adv_idx;

  logic [2:0]       first_pos;
  logic             first_found;
  logic [2:0]       first_idx;

  logic             en_r, busy_r, wrap_r;
  logic [2:0]       w_r;

  assign start_ev   = bus.start & ~start_q;
  assign stop_ev    = bus.stop  & ~stop_q;
  assign step_ev    = bus.step  & ~step_q;
  assign dwell_done = (cnt == CNT_W'(DWELL - 1));

  // Nearest eligible position from the current one in the selected direction;
  // offset 8 lands back on the current position, so a lone eligible bit wraps.
  always_comb begin
    adv_pos   = pos;
    adv_wrap  = 1'b0;
    adv_found = 1'b0;
    adv_idx   = '0;
    for (int unsigned k = 1; k <= 8; k++) begin
      adv_idx = bus.dir ? (pos - 3'(k)) : (pos + 3'(k));
      if (!adv_found && bus.mask[adv_idx]) begin
        adv_found = 1'b1;
        adv_pos   = adv_idx;
        adv_wrap  = bus.dir ? (k > 32'(pos)) : ((32'(pos) + k) > 32'd7);
      end
    end
  end

  // First eligible position when starting: upward from 0 or downward from 7.
  always_comb begin
    first_pos   = '0;
    first_found = 1'b0;
    first_idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      first_idx = bus.dir ? 3'(7 - k) : 3'(k);
      if (!first_found && bus.mask[first_idx]) begin
        first_found = 1'b1;
        first_pos   = first_idx;
      end
    end
  end

  // Control FSM, position, dwell counter and input edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pos     <= '0;
      cnt     <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
      step_q  <= bus.step;
      wrap_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ev) begin
            state <= S_RUN;
            pos   <= first_pos;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (stop_ev) begin
            state <= S_PAUSE;
            cnt   <= '0;
          end else if (dwell_done) begin
            cnt    <= '0;
            pos    <= adv_pos;
            wrap_q <= adv_wrap;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop_ev) begin
            state <= S_IDLE;
            pos   <= '0;
          end else if (start_ev) begin
            state <= S_RUN;
            cnt   <= '0;
          end else if (step_ev) begin
            pos    <= adv_pos;
            wrap_q <= adv_wrap;
          end
        end
        default: begin
          state <= S_IDLE;
          pos   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Registered decoder selects and status so the decoder never sees glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_r   <= 1'b0;
      w_r    <= '0;
      busy_r <= 1'b0;
      wrap_r <= 1'b0;
    end else begin
      en_r   <= (state != S_IDLE) && bus.mask[pos];
      w_r    <= pos;
      busy_r <= (state != S_IDLE);
      wrap_r <= wrap_q;
    end
  end

  assign bus.en   = en_r;
  assign bus.w2   = w_r[2];
  assign bus.w1   = w_r[1];
  assign bus.w0   = w_r[0];
  assign bus.busy = busy_r;
  assign bus.wrap = wrap_r;

endmodule

// File: tb/tb_select_sequencer_3bit.sv
// Directed bench for select_sequencer_3bit with a queue of expected outputs.
module tb_select_sequencer_3bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [5:0] sb [$];

  select_sequencer_3bit_if bus ();

  select_sequencer_3bit #(.DWELL(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed expectation: {en, w[2:0], busy, wrap}
  function automatic logic [5:0] pk(input logic en, input int w,
                                    input logic busy, input logic wrap);
    return {en, 3'(w), busy, wrap};
  endfunction

  task automatic compare(input string tag);
    logic [5:0] got;
    logic [5:0] exp;
    got = {bus.en, bus.w2, bus.w1, bus.w0, bus.busy, bus.wrap};
    exp = sb.pop_front();
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed={en,w,busy,wrap}=%b expected=%b", tag, got, exp);
    end
  endtask

  // Expectation for the outputs seen just after the next rising edge.
  task automatic exp_edge(input logic [5:0] e, input string tag);
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;
    bus.dir   = 1'b0;
    bus.mask  = 8'hFF;

    // Reset state
    exp_edge(pk(0, 0, 0, 0), "reset0");
    exp_edge(pk(0, 0, 0, 0), "reset1");
    rst = 1'b0;

    // Ascending full scan, dwell 4, wrap on 7->0
    bus.start = 1'b1;
    exp_edge(pk(0, 0, 0, 0), "asc_latency");
    bus.start = 1'b0;
    for (int p = 0; p < 8; p++)
      for (int c = 0; c < 4; c++)
        exp_edge(pk(1, p, 1, 0), $sformatf("asc_p%0d_c%0d", p, c));
    exp_edge(pk(1, 0, 1, 1), "asc_wrap");
    exp_edge(pk(1, 0, 1, 0), "asc_wrap_end");

    // Asynchronous reset between edges while running
    #3;
    rst = 1'b1;
    #1;
    sb.push_back(pk(0, 0, 0, 0));
    compare("async_reset_now");
    exp_edge(pk(0, 0, 0, 0), "async_reset_hold0");
    exp_edge(pk(0, 0, 0, 0), "async_reset_hold1");
    rst = 1'b0;

    // Descending over a sparse mask: 7,5,2,7 with wrap on 2->7
    bus.mask  = 8'b1010_0100;
    bus.dir   = 1'b1;
    bus.start = 1'b1;
    exp_edge(pk(0, 0, 0, 0), "desc_latency");
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) exp_edge(pk(1, 7, 1, 0), "desc_7");
    for (int c = 0; c < 4; c++) exp_edge(pk(1, 5, 1, 0), "desc_5");
    for (int c = 0; c < 4; c++) exp_edge(pk(1, 2, 1, 0), "desc_2");
    exp_edge(pk(1, 7, 1, 1), "desc_wrap");
    exp_edge(pk(1, 7, 1, 0), "desc_wrap_end");

    // Stop pauses; a held Step advances exactly once
    bus.stop = 1'b1;
    exp_edge(pk(1, 7, 1, 0), "pause_enter");
    bus.stop = 1'b0;
    exp_edge(pk(1, 7, 1, 0), "pause_hold");
    bus.step = 1'b1;
    exp_edge(pk(1, 7, 1, 0), "step_edge");
    for (int c = 0; c < 9; c++) exp_edge(pk(1, 5, 1, 0), $sformatf("step_held%0d", c));
    bus.step = 1'b0;

    // Second Stop returns to idle
    bus.stop = 1'b1;
    exp_edge(pk(1, 5, 1, 0), "stop2_edge");
    bus.stop = 1'b0;
    exp_edge(pk(0, 0, 0, 0), "stop2_idle");
    exp_edge(pk(0, 0, 0, 0), "stop2_idle_hold");

    // Start and Stop together in PAUSE: Stop wins
    bus.start = 1'b1;
    exp_edge(pk(0, 0, 0, 0), "prio_run_latency");
    bus.start = 1'b0;
    exp_edge(pk(1, 7, 1, 0), "prio_run");
    bus.stop = 1'b1;
    exp_edge(pk(1, 7, 1, 0), "prio_pause_edge");
    bus.stop = 1'b0;
    exp_edge(pk(1, 7, 1, 0), "prio_paused");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    exp_edge(pk(1, 7, 1, 0), "prio_both_edge");
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    exp_edge(pk(0, 0, 0, 0), "prio_stop_wins");

    // Single eligible position: holds, wraps every dwell; empty mask blanks
    bus.mask  = 8'b0000_1000;
    bus.dir   = 1'b0;
    bus.start = 1'b1;
    exp_edge(pk(0, 0, 0, 0), "single_latency");
    bus.start = 1'b0;
    for (int c = 0; c < 4; c++) exp_edge(pk(1, 3, 1, 0), "single_first");
    exp_edge(pk(1, 3, 1, 1), "single_wrap1");
    for (int c = 0; c < 3; c++) exp_edge(pk(1, 3, 1, 0), "single_mid");
    exp_edge(pk(1, 3, 1, 1), "single_wrap2");
    bus.mask = 8'h00;
    for (int c = 0; c < 5; c++) exp_edge(pk(0, 3, 1, 0), $sformatf("empty_mask%0d", c));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
